// File: rtl/pipe_reg_chain.sv
// Cascaded pipeline registers with per-stage stall/flush control
// and saturating bubble/flush event counters.
module pipe_reg_chain #(
  parameter int                DATA_W   = 80,
  parameter int                DEPTH    = 1,
  parameter int                BASE     = 2,
  parameter int                STALL_W  = 6,
  parameter logic [DATA_W-1:0] NOP_DATA = {DATA_W{1'b0}},
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STALL_W-1:0] stall,
  input  logic [DEPTH-1:0]  flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [DEPTH-1:0]  stage_valid,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  input  logic              clr_cnt
);

  if (DEPTH < 1 || DEPTH > 4 || BASE + DEPTH + 1 > STALL_W) begin : g_bad
    $error("pipe_reg_chain: bad DEPTH/BASE/STALL_W");
  end

  logic [DEPTH-1:0][DATA_W-1:0] w_data;
  logic [DEPTH-1:0]             w_valid;
  logic [DEPTH-1:0]             w_bub;
  logic [DEPTH-1:0]             w_kill;
  logic                         w_unused_stall;

  assign w_unused_stall = ^stall;

  for (genvar i = 0; i < DEPTH; i++) begin : g_st
    logic [DATA_W-1:0] r_d;
    logic              r_v;
    logic [DATA_W-1:0] w_src_d;
    logic              w_src_v;
    logic              w_up;
    logic              w_dn;

    if (i == 0) begin : g_head
      assign w_src_d = in_data;
      assign w_src_v = in_valid;
    end else begin : g_body
      assign w_src_d = w_data[i-1];
      assign w_src_v = w_valid[i-1];
    end

    assign w_up      = stall[BASE+i];
    assign w_dn      = stall[BASE+i+1];
    assign w_bub[i]  = !flush[i] && w_up && !w_dn;
    assign w_kill[i] = flush[i] && r_v;
    assign w_data[i]  = r_d;
    assign w_valid[i] = r_v;

    always_ff @(posedge clk) begin
      if (rst || flush[i] || (w_up && !w_dn)) begin
        r_d <= NOP_DATA;
        r_v <= 1'b0;
      end else if (!w_up) begin
        r_d <= w_src_d;
        r_v <= w_src_v;
      end
    end
  end

  logic [CNT_W:0] w_bsum;
  logic [CNT_W:0] w_fsum;

  // Sums are one bit wider so the carry flags saturation.
  always_comb begin
    w_bsum = {1'b0, bubble_cnt};
    w_fsum = {1'b0, flush_cnt};
    for (int i = 0; i < DEPTH; i++) begin
      w_bsum = w_bsum + (CNT_W+1)'(w_bub[i]);
      w_fsum = w_fsum + (CNT_W+1)'(w_kill[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      bubble_cnt <= w_bsum[CNT_W] ? {CNT_W{1'b1}} : w_bsum[CNT_W-1:0];
      flush_cnt  <= w_fsum[CNT_W] ? {CNT_W{1'b1}} : w_fsum[CNT_W-1:0];
    end
  end

  assign out_data    = w_data[DEPTH-1];
  assign out_valid   = w_valid[DEPTH-1];
  assign stage_valid = w_valid;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Randomized bench for pipe_reg_chain against a rule-level model
// plus directed saturation, clear and reset-mid-run phases.
module tb_pipe_reg_chain;
  localparam int DW = 16;
  localparam int D  = 3;
  localparam int B  = 2;
  localparam int SW = 6;
  localparam int CW = 4;
  localparam logic [DW-1:0] NOP = 16'hDEAD;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 0;
  logic          rst;
  logic [SW-1:0] stall;
  logic [D-1:0]  flush;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          clr_cnt;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic [D-1:0]  stage_valid;
  logic [CW-1:0] bubble_cnt;
  logic [CW-1:0] flush_cnt;

  pipe_reg_chain #(
    .DATA_W(DW), .DEPTH(D), .BASE(B), .STALL_W(SW),
    .NOP_DATA(NOP), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid),
    .stage_valid(stage_valid), .bubble_cnt(bubble_cnt),
    .flush_cnt(flush_cnt), .clr_cnt(clr_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] m_d[D];
  logic          m_v[D];
  int            m_bub;
  int            m_fl;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Applies the per-register priority rules to the current inputs.
  task automatic model_edge();
    logic [DW-1:0] nd[D];
    logic          nv[D];
    logic [DW-1:0] sd;
    logic          sv;
    int            nb;
    int            nf;
    nb = 0;
    nf = 0;
    for (int i = 0; i < D; i++) begin
      sd = (i == 0) ? in_data : m_d[i-1];
      sv = (i == 0) ? in_valid : m_v[i-1];
      nd[i] = m_d[i];
      nv[i] = m_v[i];
      if (flush[i]) begin
        nd[i] = NOP; nv[i] = 0;
        if (m_v[i]) nf++;
      end else if (stall[B+i] && !stall[B+i+1]) begin
        nd[i] = NOP; nv[i] = 0; nb++;
      end else if (!stall[B+i]) begin
        nd[i] = sd; nv[i] = sv;
      end
    end
    if (rst) begin
      for (int i = 0; i < D; i++) begin
        nd[i] = NOP; nv[i] = 0;
      end
      m_bub = 0; m_fl = 0;
    end else if (clr_cnt) begin
      m_bub = 0; m_fl = 0;
    end else begin
      m_bub = (m_bub + nb > CMAX) ? CMAX : m_bub + nb;
      m_fl  = (m_fl + nf > CMAX) ? CMAX : m_fl + nf;
    end
    for (int i = 0; i < D; i++) begin
      m_d[i] = nd[i];
      m_v[i] = nv[i];
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    chk({tag, ".data"}, 32'(out_data), 32'(m_d[D-1]));
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_v[D-1]));
    chk({tag, ".stv"}, 32'(stage_valid), 32'({m_v[2], m_v[1], m_v[0]}));
    chk({tag, ".bub"}, 32'(bubble_cnt), 32'(m_bub));
    chk({tag, ".fl"}, 32'(flush_cnt), 32'(m_fl));
  endtask

  initial begin
    for (int i = 0; i < D; i++) begin
      m_d[i] = 'x; m_v[i] = 1'bx;
    end
    m_bub = 0; m_fl = 0;
    rst = 1; stall = '0; flush = '0; in_data = '0;
    in_valid = 0; clr_cnt = 0;
    step("rst0");
    step("rst1");
    chk("rst.out", 32'(out_data), 32'(NOP));
    rst = 0;

    // Chain latency: 1,2,3 arrive at the output on edges 3,4,5.
    for (int k = 1; k <= 6; k++) begin
      in_data = (k <= 3) ? DW'(k) : 16'h0;
      in_valid = (k <= 3);
      step("lat");
      if (k == 3) chk("lat.first", 32'(out_data), 32'h1);
      if (k == 3) chk("lat.full", 32'(stage_valid), 32'b111);
    end

    // Hold stage 2 and kill it twice: only the first flush counts.
    in_data = 16'h55; in_valid = 1;
    step("fill0"); step("fill1"); step("fill2");
    stall = 6'b110000; flush = 3'b100;
    step("flush1");
    chk("flush1.cnt", 32'(flush_cnt), 32'd1);
    step("flush2");
    chk("flush2.cnt", 32'(flush_cnt), 32'd1);
    flush = '0;

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      stall    = ($urandom_range(0, 1) == 0) ? '0 : SW'($urandom);
      flush    = ($urandom_range(0, 7) == 0) ? D'($urandom) : '0;
      in_data  = DW'($urandom);
      in_valid = 1'($urandom);
      clr_cnt  = ($urandom_range(0, 40) == 0);
      rst      = ($urandom_range(0, 80) == 0);
      step("rnd");
    end
    rst = 0; clr_cnt = 0; flush = '0;

    // Saturation: 20 bubbles into stage 0.
    stall = 6'b000100;
    clr_cnt = 1;
    step("clr");
    clr_cnt = 0;
    for (int n = 0; n < 20; n++) step("sat");
    chk("sat.hold", 32'(bubble_cnt), 32'(CMAX));
    clr_cnt = 1;
    step("clrbub");
    chk("clrbub.zero", 32'(bubble_cnt), 32'd0);
    clr_cnt = 0;

    // Reset mid-operation with a full chain.
    stall = '0; in_valid = 1;
    for (int n = 0; n < 3; n++) begin
      in_data = DW'(16'h100 + n);
      step("refill");
    end
    chk("refill.full", 32'(stage_valid), 32'b111);
    rst = 1;
    step("midrst");
    chk("midrst.stv", 32'(stage_valid), 32'b000);
    rst = 0;
    step("post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
